board_scanner: RTL and testbench

//  Reads the 64 square piece registers back out of the board, one square per

---
 rtl/chess_pkg.sv | 17 +
 rtl/piece_out_stage.sv | 53 +++++
 rtl/board_scanner.sv | 112 +++++++++++
 tb/tb_board_scanner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared board constants and the scanner state encoding.
package chess_pkg;

  localparam int PIECE_W = 10;
  localparam int NUM_SQ  = 64;
  localparam int SQ_W    = $clog2(NUM_SQ);

  localparam logic [PIECE_W-1:0] EMPTY_PIECE = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/piece_out_stage.sv
// Single-entry output register carrying one {square, piece} beat over valid/ready.
module piece_out_stage
  import chess_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [SQ_W-1:0]    square_i,
  input  logic [PIECE_W-1:0] piece_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [SQ_W-1:0]    square_o,
  output logic [PIECE_W-1:0] piece_o
);

  logic               valid_q, valid_d;
  logic [SQ_W-1:0]    square_q, square_d;
  logic [PIECE_W-1:0] piece_q, piece_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      square_q <= '0;
      piece_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      square_q <= square_d;
      piece_q  <= piece_d;
    end
  end

  // Load only arrives when the slot is free or being emptied, so it overrides an accept.
  always_comb begin
    valid_d  = valid_q;
    square_d = square_q;
    piece_d  = piece_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d  = 1'b1;
      square_d = square_i;
      piece_d  = piece_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign square_o = square_q;
  assign piece_o  = piece_q;

endmodule

// File: rtl/board_scanner.sv
// Walks all squares through the board read mux and streams occupied ones as beats.
//   state | meaning
//   IDLE  | waiting for start
//   SCAN  | sampling one square per free output slot
//   DRAIN | last square sampled, waiting for the final beat to leave
//   DONE  | one-cycle completion pulse
module board_scanner
  import chess_pkg::*;
#(
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic [SQ_W-1:0]    rd_addr,
  input  logic [PIECE_W-1:0] rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SQ_W-1:0]    out_square,
  output logic [PIECE_W-1:0] out_piece,
  output logic               done,
  output logic [SQ_W:0]      count
);

  localparam logic [SQ_W-1:0] LAST_SQ = SQ_W'(NUM_SQ - 1);

  scan_state_e       state_q, state_d;
  logic [SQ_W-1:0]   rd_addr_q, rd_addr_d;
  logic [SQ_W:0]     count_q, count_d;
  logic              slot_free;
  logic              keep_sq;
  logic              load;
  logic              clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      count_q   <= count_d;
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign keep_sq   = (rd_data != EMPTY_PIECE) || !SKIP_EMPTY;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    count_d   = count_q;
    load      = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          rd_addr_d = '0;
          count_d   = '0;
        end
      end
      SCAN: begin
        // A stalled beat freezes the address so no square is skipped or repeated.
        if (slot_free) begin
          if (keep_sq) begin
            load    = 1'b1;
            count_d = count_q + (SQ_W+1)'(1);
          end
          if (rd_addr_q == LAST_SQ) begin
            state_d = DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + SQ_W'(1);
          end
        end
      end
      DRAIN: begin
        if (slot_free) begin
          clear   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  piece_out_stage u_out (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .clear_i  (clear),
    .square_i (rd_addr_q),
    .piece_i  (rd_data),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .square_o (out_square),
    .piece_o  (out_piece)
  );

  assign busy    = (state_q == SCAN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign rd_addr = rd_addr_q;
  assign count   = count_q;

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner: table of scan scenarios checked against a beat-list model.
module tb_board_scanner;
  import chess_pkg::*;

  typedef struct {
    int pat;      // 0 initial pos, 1 single on 63, 2 full, 3 empty, 4 random sparse
    int rmode;    // 0 ready high, 1 toggling, 2 random
    bit skip;
    int exp_cnt;  // -1: take from model only
    int exp_lat;  // -1: not checked
    int xstart;   // cycle offset of a stray start, -1 none
    bit midw;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  bit   sel;
  logic start1, start0;
  logic busy1, busy0, v1, v0, done1, done0;
  logic [SQ_W-1:0] rd_addr1, rd_addr0, sq1, sq0;
  logic [PIECE_W-1:0] rd_data1, rd_data0, pc1, pc0;
  logic [SQ_W:0] cnt1, cnt0;
  logic m_busy, m_valid, m_done;
  logic [SQ_W-1:0] m_addr, m_sq;
  logic [PIECE_W-1:0] m_pc;
  logic [SQ_W:0] m_count;
  logic [PIECE_W-1:0] board [NUM_SQ];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start1   = start & ~sel;
  assign start0   = start & sel;
  assign rd_data1 = board[rd_addr1];
  assign rd_data0 = board[rd_addr0];
  assign m_busy   = sel ? busy0 : busy1;
  assign m_valid  = sel ? v0 : v1;
  assign m_done   = sel ? done0 : done1;
  assign m_addr   = sel ? rd_addr0 : rd_addr1;
  assign m_sq     = sel ? sq0 : sq1;
  assign m_pc     = sel ? pc0 : pc1;
  assign m_count  = sel ? cnt0 : cnt1;

  board_scanner #(.SKIP_EMPTY(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .out_valid(v1), .out_ready(out_ready), .out_square(sq1),
    .out_piece(pc1), .done(done1), .count(cnt1));

  board_scanner #(.SKIP_EMPTY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .out_valid(v0), .out_ready(out_ready), .out_square(sq0),
    .out_piece(pc0), .done(done0), .count(cnt0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_board(input int pat);
    for (int k = 0; k < NUM_SQ; k++) begin
      case (pat)
        0: board[k] = (k < 16 || k >= 48) ? PIECE_W'(10'h040 + k) : '0;
        1: board[k] = (k == 63) ? 10'h2A5 : '0;
        2: board[k] = PIECE_W'($urandom_range(1, 1023));
        3: board[k] = '0;
        default: board[k] = ($urandom_range(0, 1) == 1) ? PIECE_W'($urandom_range(1, 1023)) : '0;
      endcase
    end
  endtask

  task automatic run_scan(input vec_t v);
    logic [PIECE_W-1:0] snap [NUM_SQ];
    logic [PIECE_W-1:0] val;
    int exp_sq[$];
    int exp_pc[$];
    int t0, nexp;
    bit prev_stall, finished;
    logic [SQ_W-1:0] prev_sq;
    logic [PIECE_W-1:0] prev_pc;

    fill_board(v.pat);
    for (int k = 0; k < NUM_SQ; k++) snap[k] = board[k];
    snap[10] = 10'h111;
    snap[40] = 10'h3C3;
    // Squares sampled at or after the mid-scan write (k >= 29 at full rate) see the new value.
    for (int k = 0; k < NUM_SQ; k++) begin
      val = (v.midw && k >= 29) ? snap[k] : board[k];
      if (val != 0 || !v.skip) begin
        exp_sq.push_back(k);
        exp_pc.push_back(int'(val));
      end
    end
    nexp = exp_sq.size();

    @(posedge clk); #1;
    sel = !v.skip;
    start = 1'b1;
    out_ready = 1'b1;
    t0 = cyc;
    prev_stall = 1'b0;
    prev_sq = '0;
    prev_pc = '0;
    finished = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      @(posedge clk); #1;
      start = (v.xstart >= 0) && (cyc - t0 == v.xstart);
      case (v.rmode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc - t0) % 2) == 1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (v.midw && cyc - t0 == 30) begin
        board[10] = snap[10];
        board[40] = snap[40];
      end
      @(negedge clk);
      if (cyc - t0 == 1) begin
        chk("busy_after_start", m_busy, 1);
        chk("first_addr", m_addr, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_square", m_sq, prev_sq);
        chk("stall_piece", m_pc, prev_pc);
      end
      if (m_valid && out_ready) begin
        if (exp_sq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_beat: got square %0d piece %0d, required no beat", m_sq, m_pc);
        end else begin
          chk("beat_square", m_sq, exp_sq.pop_front());
          chk("beat_piece", m_pc, exp_pc.pop_front());
          if (v.rmode == 0) chk("beat_latency", cyc - t0, m_sq + 2);
        end
      end
      prev_stall = m_valid && !out_ready;
      prev_sq = m_sq;
      prev_pc = m_pc;
      if (m_done) begin
        finished = 1'b1;
        chk("done_busy_low", m_busy, 0);
        chk("beats_missing", exp_sq.size(), 0);
        chk("count_model", m_count, nexp);
        if (v.exp_cnt >= 0) chk("count_table", m_count, v.exp_cnt);
        if (v.exp_lat >= 0) chk("done_latency", cyc - t0, v.exp_lat);
      end else begin
        chk("busy_during_scan", m_busy, 1);
      end
    end
    if (!finished) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done within 400 cycles, required one done pulse");
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", m_done, 0);
    chk("count_hold", m_count, nexp);
  endtask

  initial begin
    int t0;
    vec_t vr;
    vecs[0] = '{0, 0, 1'b1, 32, 66, -1, 1'b0};
    vecs[1] = '{1, 0, 1'b1, 1, 66, -1, 1'b0};
    vecs[2] = '{2, 1, 1'b1, 64, -1, -1, 1'b0};
    vecs[3] = '{3, 0, 1'b0, 64, 66, -1, 1'b0};
    vecs[4] = '{3, 0, 1'b1, 0, 66, -1, 1'b0};
    vecs[5] = '{4, 2, 1'b1, -1, -1, -1, 1'b0};
    vecs[6] = '{4, 0, 1'b1, -1, 66, -1, 1'b1};
    vecs[7] = '{2, 0, 1'b1, 64, 66, 10, 1'b0};
    vecs[8] = '{4, 2, 1'b0, 64, -1, -1, 1'b0};
    vecs[9] = '{2, 2, 1'b0, 64, -1, -1, 1'b0};

    for (int k = 0; k < NUM_SQ; k++) board[k] = '0;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_addr", rd_addr1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_square", sq1, 0);
    chk("rst_piece", pc1, 0);
    chk("rst_done", done1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_valid0", v0, 0);
    chk("rst_count0", cnt0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_scan(vecs[i]);

    // Abort mid-scan, with a coincident start that reset must override.
    fill_board(2);
    @(posedge clk); #1;
    sel = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("abort_no_done", m_done, 0);
    end
    chk("abort_beat_pending", m_valid, 1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_cycle", cyc - t0, 21);
    chk("abort_busy", m_busy, 0);
    chk("abort_addr", m_addr, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_square", m_sq, 0);
    chk("abort_piece", m_pc, 0);
    chk("abort_done", m_done, 0);
    chk("abort_count", m_count, 0);
    while (cyc - t0 < 24) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_idle_done", m_done, 0);
      chk("abort_idle_busy", m_busy, 0);
    end
    vr = '{2, 0, 1'b1, 64, 66, -1, 1'b0};
    run_scan(vr);

    for (int i = 0; i < 3; i++) begin
      vr = '{4, int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1), -1, -1, -1, 1'b0};
      run_scan(vr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
